// File: rtl/freqdiv_ctrl.sv
// Run-time reconfigurable integer clock divider with a divisor-update
// controller. New divisors are accepted over valid/ready and applied only
// at a period boundary. `locked` is held low until enough full periods
// have run at the new ratio.
module freqdiv_ctrl #(
    parameter int unsigned CNT_W          = 28,
    parameter int unsigned DIV_DEFAULT    = 15,
    parameter int unsigned SETTLE_PERIODS = 4
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic [CNT_W-1:0] div_in,
    input  logic             div_valid,
    output logic             div_ready,
    output logic             clock_out,
    output logic             period_tick,
    output logic             locked,
    output logic [CNT_W-1:0] div_active,
    output logic             err_bad_div
);

    localparam int unsigned SET_W = (SETTLE_PERIODS > 1) ? $clog2(SETTLE_PERIODS) : 1;
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_PERIODS - 1);
    localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DIV_DEFAULT);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        PENDING = 2'd1,
        SETTLE  = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   counter;
    logic [CNT_W-1:0]   shadow, shadow_n;
    logic [CNT_W-1:0]   div_n;
    logic [SET_W-1:0]   settle_cnt, settle_n;
    logic               skip_tick, skip_n;
    logic               locked_n;
    logic               err_n;
    logic               wrap;

    // Terminal count of the current period
    assign wrap = (counter >= (div_active - CNT_W'(1)));

    // Requests are only taken while running at a stable ratio
    assign div_ready = (state == RUN);

    // Divide counter and the registered clock/tick outputs
    always_ff @(posedge clock_in) begin
        if (reset) begin
            counter     <= '0;
            clock_out   <= 1'b0;
            period_tick <= 1'b0;
        end else begin
            counter     <= wrap ? '0 : counter + CNT_W'(1);
            clock_out   <= (counter < (div_active >> 1));
            period_tick <= wrap;
        end
    end

    // Controller state register
    always_ff @(posedge clock_in) begin
        if (reset) begin
            state       <= SETTLE;
            shadow      <= DIV_RST;
            div_active  <= DIV_RST;
            settle_cnt  <= '0;
            skip_tick   <= 1'b0;
            locked      <= 1'b0;
            err_bad_div <= 1'b0;
        end else begin
            state       <= state_n;
            shadow      <= shadow_n;
            div_active  <= div_n;
            settle_cnt  <= settle_n;
            skip_tick   <= skip_n;
            locked      <= locked_n;
            err_bad_div <= err_n;
        end
    end

    // Next-state logic: accept, swap at boundary, count settling periods.
    // skip_tick masks the tick produced by the swap edge itself so that
    // only full periods at the new divisor count toward settling.
    always_comb begin
        state_n  = state;
        shadow_n = shadow;
        div_n    = div_active;
        settle_n = settle_cnt;
        skip_n   = 1'b0;
        locked_n = locked;
        err_n    = 1'b0;
        case (state)
            RUN: begin
                if (div_valid) begin
                    if (div_in < CNT_W'(2)) begin
                        err_n = 1'b1;
                    end else begin
                        shadow_n = div_in;
                        state_n  = PENDING;
                        locked_n = 1'b0;
                    end
                end
            end
            PENDING: begin
                if (wrap) begin
                    div_n    = shadow;
                    settle_n = '0;
                    skip_n   = 1'b1;
                    state_n  = SETTLE;
                end
            end
            SETTLE: begin
                if (period_tick && !skip_tick) begin
                    if (settle_cnt == SET_LAST) begin
                        state_n  = RUN;
                        locked_n = 1'b1;
                        settle_n = '0;
                    end else begin
                        settle_n = settle_cnt + SET_W'(1);
                    end
                end
            end
            default: begin
                state_n = SETTLE;
            end
        endcase
    end

endmodule
